// File: rtl/buf_pkg.sv
// buf_pkg: state encoding and MIPS constants shared by the buf_stage slice.
package buf_pkg;

    // sll $0,$0,0 encodes as all zeros; used as the bubble instruction.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding at the maximum value.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/buf_stage.sv
// buf_stage: generic pipeline stage register carrying {pc_plus4, instruccion}
// with a valid/ready handshake and a one-word skid so in_ready comes straight
// from a flop. Optional upstream stall counter enabled by BUF_STAGE_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | nothing held; outputs show NOP_INSTR / 0
// ST_ONE   | main register holds the head word; skid empty
// ST_TWO   | main holds head, skid holds the next word; in_ready low
module buf_stage
    import buf_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(MIPS_NOP)
`ifdef BUF_STAGE_STATS_EN
    ,
    parameter int                 CNT_W     = 16
`endif
) (
    input  logic               clk_buf_stage,
    input  logic               reset_buf_stage,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruccion_in,
    input  logic [PC_W-1:0]    pc_plus4_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruccion_out,
    output logic [PC_W-1:0]    pc_plus4_out
`ifdef BUF_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    buf_state_t         state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               in_fire;
    logic               out_fire;

    // Handshake flags come only from the state flop, never from inputs.
    assign out_valid       = (state_q != ST_EMPTY);
    assign in_ready        = (state_q != ST_TWO);
    assign in_fire         = in_valid & in_ready;
    assign out_fire        = out_valid & out_ready;
    assign instruccion_out = main_instr_q;
    assign pc_plus4_out    = main_pc_q;

    // Next-state and payload steering; flush overrides every fire.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        main_instr_d = instruccion_in;
                        main_pc_d    = pc_plus4_in;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = instruccion_in;
                        main_pc_d    = pc_plus4_in;
                    end else if (in_fire) begin
                        state_d      = ST_TWO;
                        skid_instr_d = instruccion_in;
                        skid_pc_d    = pc_plus4_in;
                    end else if (out_fire) begin
                        state_d      = ST_EMPTY;
                        main_instr_d = NOP_INSTR;
                        main_pc_d    = '0;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d      = ST_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_pc_d    = '0;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_buf_stage or negedge reset_buf_stage) begin
        if (!reset_buf_stage) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef BUF_STAGE_STATS_EN
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_sys (clk_buf_stage),
        .rst_b   (reset_buf_stage),
        .en      (in_valid & ~in_ready),
        .count   (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_buf_stage.sv
// tb_buf_stage: directed scoreboard bench for buf_stage.
// Stall-counter checks are compiled in when BUF_STAGE_STATS_EN is defined.
module tb_buf_stage;

    logic        clk_buf_stage = 1'b0;
    logic        reset_buf_stage;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruccion_in;
    logic [31:0] pc_plus4_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruccion_out;
    logic [31:0] pc_plus4_out;
`ifdef BUF_STAGE_STATS_EN
    logic [3:0]  stall_cnt;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          n_out        = 0;
    int          n0;
    logic [63:0] sb[$];

    always #5 clk_buf_stage = ~clk_buf_stage;

    buf_stage #(
        .INSTR_W   (32),
        .PC_W      (32),
        .NOP_INSTR (32'h0)
`ifdef BUF_STAGE_STATS_EN
        ,
        .CNT_W     (4)
`endif
    ) dut (
        .clk_buf_stage   (clk_buf_stage),
        .reset_buf_stage (reset_buf_stage),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instruccion_in  (instruccion_in),
        .pc_plus4_in     (pc_plus4_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .instruccion_out (instruccion_out),
        .pc_plus4_out    (pc_plus4_out)
`ifdef BUF_STAGE_STATS_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid       = v;
        instruccion_in = instr;
        pc_plus4_in    = pc;
    endtask

    // Score the handshake of the current cycle, then advance to edge + 1.
    task automatic tick();
        logic [63:0] exp;
        if (out_valid && out_ready) begin
            n_out++;
            tests_run++;
            assert (sb.size() != 0) else begin
                tests_failed++;
                $error("FAIL sb_underflow: observed word %h, expected no output", {instruccion_out, pc_plus4_out});
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("out_word", {instruccion_out, pc_plus4_out}, exp);
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back({instruccion_in, pc_plus4_in});
        @(posedge clk_buf_stage);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_buf_stage = 1'b1;
        flush           = 1'b0;
        out_ready       = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2 reset_buf_stage = 1'b0;
        @(posedge clk_buf_stage);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_instr",     64'(instruccion_out), 64'h0);
        check("rst_pc",        64'(pc_plus4_out), 64'h0);
        reset_buf_stage = 1'b1;

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        n0 = n_out;
        drive(1'b1, 32'h2008_0005, 32'h4);
        tick();
        check("s_a_instr", 64'(instruccion_out), 64'h2008_0005);
        check("s_a_valid", 64'(out_valid), 64'd1);
        check("s_a_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h2009_0007, 32'h8);
        tick();
        check("s_b_instr", 64'(instruccion_out), 64'h2009_0007);
        check("s_b_pc",    64'(pc_plus4_out), 64'h8);
        check("s_b_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("s_empty", 64'(out_valid), 64'd0);
        check("s_count", 64'(n_out - n0), 64'd2);

        // Fill to TWO with downstream blocked, then drain.
        out_ready = 1'b0;
        n0 = n_out;
        drive(1'b1, 32'h1111_1111, 32'h100);
        tick();
        drive(1'b1, 32'h2222_2222, 32'h104);
        tick();
        check("f_ready_low", 64'(in_ready), 64'd0);
        check("f_valid",     64'(out_valid), 64'd1);
        check("f_head",      64'(instruccion_out), 64'h1111_1111);
        drive(1'b1, 32'h3333_3333, 32'h108);
        tick();
        check("f_hold_instr", 64'(instruccion_out), 64'h1111_1111);
        check("f_hold_pc",    64'(pc_plus4_out), 64'h100);
        check("f_still_full", 64'(in_ready), 64'd0);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        tick();
        check("f_second", 64'(instruccion_out), 64'h2222_2222);
        tick();
        check("f_drained", 64'(out_valid), 64'd0);
        check("f_sb_empty", 64'(sb.size()), 64'd0);
        check("f_count", 64'(n_out - n0), 64'd2);

        // Flush with a word held and another presented.
        out_ready = 1'b0;
        n0 = n_out;
        drive(1'b1, 32'h4444_4444, 32'h200);
        tick();
        check("fl_loaded", 64'(out_valid), 64'd1);
        flush = 1'b1;
        drive(1'b1, 32'h5555_5555, 32'h204);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_instr", 64'(instruccion_out), 64'h0);
        check("fl_pc",    64'(pc_plus4_out), 64'h0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("fl_no_emerge", 64'(out_valid), 64'd0);
        check("fl_count", 64'(n_out - n0), 64'd0);

        // Back-to-back in/out: one word per cycle, state stays ONE.
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4));
            tick();
            check("tp_valid", 64'(out_valid), 64'd1);
            check("tp_ready", 64'(in_ready), 64'd1);
        end
        check("tp_rate", 64'(n_out - n0), 64'd9);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("tp_total", 64'(n_out - n0), 64'd10);
        check("tp_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        drive(1'b1, 32'h6666_6666, 32'h300);
        tick();
        drive(1'b1, 32'h7777_7777, 32'h304);
        tick();
        check("mr_full", 64'(in_ready), 64'd0);
        #2 reset_buf_stage = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ready", 64'(in_ready), 64'd1);
        check("mr_instr", 64'(instruccion_out), 64'h0);
        check("mr_pc",    64'(pc_plus4_out), 64'h0);
        sb.delete();
        drive(1'b0, 32'h0, 32'h0);
        @(posedge clk_buf_stage);
        #1;
        reset_buf_stage = 1'b1;

        // Hold full with upstream pushing for 20 cycles, then flush.
        out_ready = 1'b0;
        drive(1'b1, 32'h8888_8888, 32'h400);
        tick();
        drive(1'b1, 32'h9999_9999, 32'h404);
        tick();
        drive(1'b1, 32'hAAAA_AAAA, 32'h408);
        repeat (5) tick();
`ifdef BUF_STAGE_STATS_EN
        check("st_partial", 64'(stall_cnt), 64'd5);
`endif
        repeat (15) tick();
        check("st_head_kept", 64'(instruccion_out), 64'h8888_8888);
`ifdef BUF_STAGE_STATS_EN
        check("st_saturated", 64'(stall_cnt), 64'd15);
`endif
        flush = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        flush = 1'b0;
        check("st_flushed", 64'(out_valid), 64'd0);
`ifdef BUF_STAGE_STATS_EN
        check("st_kept_on_flush", 64'(stall_cnt), 64'd15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
